// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and its scoreboard.
// Holds register-file geometry, requester identities and the valid-index mask helper.
package wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int NIDX      = 1 << REG_IDX_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    // Bits that may ever be busy: register 0 is hardwired, indices >= n do not exist.
    function automatic logic [NIDX-1:0] reg_mask(input int unsigned n);
        logic [NIDX-1:0] m;
        m = '0;
        for (int unsigned i = 1; i < NIDX; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin grant between the ALU and load-unit writeback requesters.
// The pointer only moves on a contended grant; grants are suppressed during reset.
module rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic alu_grant,
    output logic lsu_grant
);

    req_e ptr;
    req_e ptr_next;

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        ptr_next  = ptr;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                if (ptr == REQ_LSU) begin
                    lsu_grant = 1'b1;
                    ptr_next  = REQ_ALU;
                end else begin
                    alu_grant = 1'b1;
                    ptr_next  = REQ_LSU;
                end
            end else begin
                alu_grant = alu_valid;
                lsu_grant = lsu_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_LSU;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writebacks onto one register-file port
// and keeps a busy scoreboard that stalls dispatch on RAW/WAW hazards.
module wb_arbiter #(
    parameter int NREG = wb_arbiter_pkg::NREG
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] issue_rd,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] rs1,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] rs2,
    output logic                                 stall,
    input  logic                                 alu_valid,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] alu_rd,
    input  logic [wb_arbiter_pkg::XLEN-1:0]      alu_data,
    output logic                                 alu_ready,
    input  logic                                 lsu_valid,
    input  logic [wb_arbiter_pkg::REG_IDX_W-1:0] lsu_rd,
    input  logic [wb_arbiter_pkg::XLEN-1:0]      lsu_data,
    output logic                                 lsu_ready,
    output logic                                 rf_regwrite,
    output logic [wb_arbiter_pkg::REG_IDX_W-1:0] rf_rd,
    output logic [wb_arbiter_pkg::XLEN-1:0]      rf_regdata,
    output logic [wb_arbiter_pkg::NIDX-1:0]      busy_vec
);

    import wb_arbiter_pkg::*;

    localparam logic [NIDX-1:0] VALID_MASK = reg_mask(NREG);

    logic [NIDX-1:0]      busy;
    logic [NIDX-1:0]      set_vec;
    logic [NIDX-1:0]      clr_vec;
    logic                 alu_xfer;
    logic                 lsu_xfer;
    logic                 wb_xfer;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .alu_grant (alu_ready),
        .lsu_grant (lsu_ready)
    );

    // busy[0] is never set, so index 0 cannot contribute to a stall.
    assign stall = !rst && issue_valid && (busy[rs1] || busy[rs2] || busy[issue_rd]);

    assign alu_xfer = alu_valid && alu_ready;
    assign lsu_xfer = lsu_valid && lsu_ready;
    assign wb_xfer  = alu_xfer || lsu_xfer;
    assign wb_rd    = lsu_xfer ? lsu_rd   : alu_rd;
    assign wb_data  = lsu_xfer ? lsu_data : alu_data;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && !stall && issue_rd != '0) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (wb_xfer) begin
            clr_vec[wb_rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-edge reissue keeps the bit busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & VALID_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_regwrite <= 1'b0;
            rf_rd       <= '0;
            rf_regdata  <= '0;
        end else begin
            rf_regwrite <= wb_xfer && (wb_rd != '0);
            if (wb_xfer && (wb_rd != '0)) begin
                rf_rd      <= wb_rd;
                rf_regdata <= wb_data;
            end
        end
    end

    assign busy_vec = busy;

endmodule
